// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_arb_pkg
// Description : Shared types and constants for the data-memory arbiter:
//               FSM state encoding, requester port ids and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_arb_pkg;

    // Arbiter FSM states, explicitly one bit wide.
    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Requester ids; also the encoding of the round-robin pointer.
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LDR  = 1'b1;

    // Default geometry of the shared data memory and the lock burst limit.
    localparam int DEF_AW       = 8;
    localparam int DEF_DW       = 8;
    localparam int DEF_LOCK_MAX = 16;

endpackage
`default_nettype wire

// File: rtl/dm_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : dm_arb_rr
// Description : Two-way round-robin picker. With a single request that
//               requester is chosen; with both, the port that was not
//               granted most recently (the one i_ptr does not name) wins.
// Ports       : i_req_core - core request
//               i_req_ldr  - loader request
//               i_ptr      - port id of the most recent grant
//               o_gnt      - one-hot grant, bit 0 = core, bit 1 = loader
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arb_rr
    import dm_arb_pkg::*;
(
    input  logic       i_req_core,
    input  logic       i_req_ldr,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_req_core && i_req_ldr) begin
            o_gnt = (i_ptr == PORT_LDR) ? 2'b01 : 2'b10;
        end else begin
            o_gnt = {i_req_ldr, i_req_core};
        end
    end

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Arbitrates a single-port data memory between a core and a
//               loader. Round-robin in ARB; the loader may hold the memory
//               in LOCK for up to LOCK_MAX consecutive grants. Read data is
//               returned one cycle after a granted read.
// Ports       : clk, reset (sync, active low)
//               c_req/c_we/c_addr/c_wdata -> c_gnt, c_rdata, c_rvalid
//               l_req/l_we/l_lock/l_addr/l_wdata -> l_gnt, l_rdata, l_rvalid
//               mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
//               conflict_cnt - saturating count of cycles with a denial
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic [DW-1:0] c_rdata,
    output logic          c_rvalid,
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic [DW-1:0] l_rdata,
    output logic          l_rvalid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [7:0]    conflict_cnt
);

    localparam int          CW         = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_MAX);

    arb_state_t    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic          r_ptr;
    // Set on forced release; blocks re-locking until l_lock is seen low.
    logic          r_block, w_block_nxt;
    logic [1:0]    w_rr_gnt;
    logic          w_held;
    logic          w_c_gnt, w_l_gnt;
    logic          w_denied;
    logic [7:0]    r_conflict;
    logic          r_c_rvalid, r_l_rvalid;
    logic [DW-1:0] r_c_rdata, r_l_rdata;

    dm_arb_rr u_rr (
        .i_req_core (c_req),
        .i_req_ldr  (l_req),
        .i_ptr      (r_ptr),
        .o_gnt      (w_rr_gnt)
    );

    // The lock only holds while the loader keeps both l_req and l_lock
    // high; otherwise this cycle is arbitrated as in ARB, so the core can
    // be granted on the very cycle the loader lets go.
    assign w_held    = (r_state == LOCK) && l_req && l_lock;
    assign w_cnt_inc = r_cnt + CW'(1);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ARB;
            r_cnt   <= '0;
            r_ptr   <= PORT_LDR;
            r_block <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_block <= w_block_nxt;
            if (w_c_gnt) begin
                r_ptr <= PORT_CORE;
            end else if (w_l_gnt) begin
                r_ptr <= PORT_LDR;
            end
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_block_nxt = r_block && l_lock;
        case (r_state)
            ARB: begin
                if (w_l_gnt && l_lock && !r_block) begin
                    if (LOCK_MAX > 1) begin
                        w_state_nxt = LOCK;
                        w_cnt_nxt   = CW'(1);
                    end else begin
                        w_block_nxt = 1'b1;
                    end
                end
            end
            LOCK: begin
                if (w_held) begin
                    if (w_cnt_inc >= LOCK_LIMIT) begin
                        w_state_nxt = ARB;
                        w_cnt_nxt   = '0;
                        w_block_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_state_nxt = ARB;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ARB;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_c_gnt   = 1'b0;
        w_l_gnt   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            if (w_held) begin
                w_l_gnt = 1'b1;
            end else begin
                w_c_gnt = w_rr_gnt[0];
                w_l_gnt = w_rr_gnt[1];
            end
        end
        if (w_c_gnt) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (w_l_gnt) begin
            mem_we    = l_we;
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end
    end

    // ------------------------------------------------ read return, counters
    assign w_denied = (c_req && !w_c_gnt) || (l_req && !w_l_gnt);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_c_rvalid <= 1'b0;
            r_l_rvalid <= 1'b0;
            r_c_rdata  <= '0;
            r_l_rdata  <= '0;
            r_conflict <= '0;
        end else begin
            r_c_rvalid <= w_c_gnt && !c_we;
            r_l_rvalid <= w_l_gnt && !l_we;
            if (w_c_gnt && !c_we) begin
                r_c_rdata <= mem_rdata;
            end
            if (w_l_gnt && !l_we) begin
                r_l_rdata <= mem_rdata;
            end
            if (w_denied && (r_conflict != 8'hFF)) begin
                r_conflict <= r_conflict + 8'd1;
            end
        end
    end

    assign c_gnt        = w_c_gnt;
    assign l_gnt        = w_l_gnt;
    assign c_rvalid     = r_c_rvalid;
    assign l_rvalid     = r_l_rvalid;
    assign c_rdata      = r_c_rdata;
    assign l_rdata      = r_l_rdata;
    assign conflict_cnt = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Directed self-checking bench for dm_arbiter. The memory is
//               modelled as rdata = addr ^ 0xA5 (addr 0x03 -> 0xA6,
//               addr 0x04 -> 0xA1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    logic       clk;
    logic       reset;
    logic       c_req, c_we, l_req, l_we, l_lock;
    logic [7:0] c_addr, c_wdata, l_addr, l_wdata;
    logic       c_gnt, c_rvalid, l_gnt, l_rvalid, mem_we;
    logic [7:0] c_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata, conflict_cnt;

    int vectors;
    int miscompares;

    dm_arbiter #(.AW(8), .DW(8), .LOCK_MAX(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .c_req        (c_req),
        .c_we         (c_we),
        .c_addr       (c_addr),
        .c_wdata      (c_wdata),
        .c_gnt        (c_gnt),
        .c_rdata      (c_rdata),
        .c_rvalid     (c_rvalid),
        .l_req        (l_req),
        .l_we         (l_we),
        .l_lock       (l_lock),
        .l_addr       (l_addr),
        .l_wdata      (l_wdata),
        .l_gnt        (l_gnt),
        .l_rdata      (l_rdata),
        .l_rvalid     (l_rvalid),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    assign mem_rdata = mem_addr ^ 8'hA5;

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        l_req = 0; l_we = 0; l_lock = 0; l_addr = 0; l_wdata = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        tick();
        reset = 1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk         = 0;
        reset       = 0;
        idle();

        // ---- reset: requests are ignored, state cleared
        c_req = 1; c_we = 1; l_req = 1;
        #1;
        chk1("rst_c_gnt", c_gnt, 1'b0);
        chk1("rst_l_gnt", l_gnt, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        tick();
        tick();
        chk8("rst_conflict", conflict_cnt, 8'd0);
        chk1("rst_c_rvalid", c_rvalid, 1'b0);
        chk1("rst_l_rvalid", l_rvalid, 1'b0);
        chk8("rst_c_rdata", c_rdata, 8'h00);
        chk8("rst_l_rdata", l_rdata, 8'h00);
        idle();
        reset = 1;

        // ---- core-only write
        c_req = 1; c_we = 1; c_addr = 8'h1E; c_wdata = 8'h5A;
        #1;
        chk1("wr_c_gnt", c_gnt, 1'b1);
        chk1("wr_l_gnt", l_gnt, 1'b0);
        chk1("wr_mem_we", mem_we, 1'b1);
        chk8("wr_mem_addr", mem_addr, 8'h1E);
        chk8("wr_mem_wdata", mem_wdata, 8'h5A);
        tick();
        chk8("wr_conflict", conflict_cnt, 8'd0);
        chk1("wr_no_rvalid", c_rvalid, 1'b0);
        idle();
        c_addr = 8'h33; c_wdata = 8'h44;
        #1;
        chk8("idle_mem_addr", mem_addr, 8'h00);
        chk8("idle_mem_wdata", mem_wdata, 8'h00);
        chk1("idle_mem_we", mem_we, 1'b0);

        // ---- contention of two readers right after reset
        do_reset();
        c_req = 1; c_addr = 8'h03; l_req = 1; l_addr = 8'h04;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("rr_c_gnt", c_gnt, (i % 2) == 0);
            chk1("rr_l_gnt", l_gnt, (i % 2) == 1);
            tick();
            chk1("rr_c_rvalid", c_rvalid, (i % 2) == 0);
            chk1("rr_l_rvalid", l_rvalid, (i % 2) == 1);
            chk8("rr_c_rdata", c_rdata, 8'hA6);
            if (i > 0) chk8("rr_l_rdata", l_rdata, 8'hA1);
        end
        chk8("rr_conflict", conflict_cnt, 8'd4);
        idle();
        tick();
        chk1("rr_c_rvalid_drop", c_rvalid, 1'b0);
        chk1("rr_l_rvalid_drop", l_rvalid, 1'b0);

        // ---- forced release after 16 locked grants
        c_req = 1; c_we = 1; c_addr = 8'h20;   // make the core the last grantee
        #1;
        chk1("pre_lock_c_gnt", c_gnt, 1'b1);
        tick();
        c_we = 0; c_addr = 8'h03;
        l_req = 1; l_we = 1; l_lock = 1; l_addr = 8'h10; l_wdata = 8'h77;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk1("lock_l_gnt", l_gnt, 1'b1);
            chk1("lock_c_gnt", c_gnt, 1'b0);
            tick();
        end
        chk8("lock_conflict16", conflict_cnt, 8'd20);
        chk1("lock_write_no_rvalid", l_rvalid, 1'b0);
        #1;
        chk1("rel17_c_gnt", c_gnt, 1'b1);
        chk1("rel17_l_gnt", l_gnt, 1'b0);
        tick();
        chk1("rel17_c_rvalid", c_rvalid, 1'b1);
        chk8("rel17_c_rdata", c_rdata, 8'hA6);
        #1;
        chk1("rel18_l_gnt", l_gnt, 1'b1);
        tick();
        #1;
        chk1("rel19_c_gnt_nolock", c_gnt, 1'b1);
        chk1("rel19_l_gnt", l_gnt, 1'b0);
        tick();
        #1;
        chk1("rel20_l_gnt", l_gnt, 1'b1);
        tick();
        chk8("rel_conflict", conflict_cnt, 8'd24);
        idle();
        tick();

        // ---- lock dropped after three grants
        c_req = 1; c_we = 1; c_addr = 8'h21;
        #1;
        chk1("pre_drop_c_gnt", c_gnt, 1'b1);
        tick();
        c_we = 0; c_addr = 8'h03;
        l_req = 1; l_we = 0; l_lock = 1; l_addr = 8'h04;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("drop_l_gnt", l_gnt, 1'b1);
            tick();
        end
        l_lock = 0;
        #1;
        chk1("drop_c_gnt", c_gnt, 1'b1);
        chk1("drop_l_gnt_off", l_gnt, 1'b0);
        tick();
        chk8("drop_conflict", conflict_cnt, 8'd28);
        idle();
        tick();

        // ---- reset during LOCK coinciding with a granted read
        c_req = 1; c_addr = 8'h03;
        l_req = 1; l_we = 0; l_lock = 1; l_addr = 8'h04;
        #1;
        chk1("mid_enter_l_gnt", l_gnt, 1'b1);
        tick();
        reset = 0;
        #1;
        chk1("mid_rst_l_gnt", l_gnt, 1'b0);
        chk1("mid_rst_c_gnt", c_gnt, 1'b0);
        tick();
        chk1("mid_rst_l_rvalid", l_rvalid, 1'b0);
        chk8("mid_rst_conflict", conflict_cnt, 8'd0);
        chk8("mid_rst_l_rdata", l_rdata, 8'h00);
        reset = 1;
        #1;
        chk1("post_rst_c_gnt", c_gnt, 1'b1);
        chk1("post_rst_l_gnt", l_gnt, 1'b0);
        tick();
        chk1("post_rst_c_rvalid", c_rvalid, 1'b1);
        chk8("post_rst_c_rdata", c_rdata, 8'hA6);
        chk8("post_rst_conflict", conflict_cnt, 8'd1);

        // ---- saturation of the conflict counter
        do_reset();
        c_req = 1; c_addr = 8'h03; l_req = 1; l_addr = 8'h04;
        repeat (254) tick();
        chk8("sat_254", conflict_cnt, 8'd254);
        repeat (46) tick();
        chk8("sat_255", conflict_cnt, 8'd255);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter AW, default 8, data-memory address width.
REQ-002 Parameter DW, default 8, data-memory word width.
REQ-003 Parameter LOCK_MAX, default 16, maximum consecutive loader cycles held under lock.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 c_req / c_we  input  1 each  core access request / write enable.
REQ-007 c_addr  input  AW, c_wdata  input  DW  core address / write data.
REQ-008 c_gnt  output  1  core access accepted this cycle.
REQ-009 c_rdata  output  DW, c_rvalid  output  1  core read data, valid one cycle after a granted read.
REQ-010 l_req / l_we / l_lock  input  1 each  loader request / write enable / burst-lock request.
REQ-011 l_addr  input  AW, l_wdata  input  DW  loader address / write data.
REQ-012 l_gnt  output  1, l_rdata  output  DW, l_rvalid  output  1  loader equivalents of REQ-008/009.
REQ-013 mem_we  output  1, mem_addr  output  AW, mem_wdata  output  DW  shared data-memory port.
REQ-014 mem_rdata  input  DW  combinational read data for mem_addr.
REQ-015 conflict_cnt  output  8  saturating count of cycles in which a requester was denied.

Function
REQ-016 Grants are combinational in the request cycle; at most one of c_gnt/l_gnt is high per cycle.
REQ-017 mem_addr/mem_wdata come from the granted port; mem_we = granted port's we; with no grant, mem_we=0 and mem_addr/mem_wdata=0.
REQ-018 FSM states: ARB, LOCK.
REQ-019 ARB, single requester: that requester is granted.
REQ-020 ARB, both requesting: the port not granted most recently wins (1-bit round-robin pointer); pointer updates to the winner on every grant.
REQ-021 ARB -> LOCK when the loader is granted with l_lock=1; lock counter loads 1.
REQ-022 LOCK: l_gnt = l_req; c_gnt=0 regardless of c_req; the counter increments on each loader grant.
REQ-023 LOCK -> ARB when l_req=0 or l_lock=0 (evaluated that cycle, no grant issued in LOCK on that cycle if l_req=0), or when the counter reaches LOCK_MAX after that cycle's grant (forced release).
REQ-024 After forced release the pointer names the loader, so the core wins the next contention cycle; l_lock must drop before the loader may re-lock.
REQ-025 Reads: on a granted read, mem_rdata is registered into that port's rdata at the clock edge and its rvalid is high for exactly the following cycle; the other port's rdata/rvalid are unchanged / low.
REQ-026 Writes never assert rvalid.
REQ-027 conflict_cnt increments by 1 for each cycle in which a port has req=1 and gnt=0; it saturates at 255.
REQ-028 Back-to-back grants to the same port on consecutive cycles are allowed with no bubble.

Reset
REQ-029 While reset=0 at a clock edge: state=ARB, pointer=loader (core wins first contention), lock counter=0, conflict_cnt=0, c_rvalid=l_rvalid=0, c_rdata=l_rdata=0.
REQ-030 While reset=0, c_gnt=l_gnt=0 and mem_we=0 combinationally; reset mid-LOCK or mid-read discards the pending rvalid.

Structure
REQ-031 Package dm_arb_pkg holds the state enum (ARB, LOCK), the port-id encoding (PORT_CORE=0, PORT_LDR=1), and the default AW/DW/LOCK_MAX constants.
REQ-032 Sub-module dm_arb_rr: a 2-way round-robin picker (inputs: two requests and pointer; output: one-hot grant) instantiated once; the FSM, counters and data-return registers stay in dm_arbiter.

Verification
REQ-033 Core-only write of 0x5A at address 0x1E -> c_gnt=1 in the same cycle, mem_we=1, mem_addr=0x1E, mem_wdata=0x5A, conflict_cnt stays 0.
REQ-034 Both request reads, from address 0x03 (core) and address 0x04 (loader), held 4 cycles after reset -> grants alternate core, loader, core, loader; rvalid follows each grant by 1 cycle with the matching memory byte; conflict_cnt=4.
REQ-035 Loader granted with l_lock=1 and l_req held for 20 cycles while the core requests -> loader is granted 16 consecutive cycles, then the core is granted on cycle 17, l_lock is ignored until it deasserts, and conflict_cnt increases by 16.
REQ-036 Loader lock with l_lock dropped after 3 grants while the core requests -> the core is granted on the cycle l_lock=0.
REQ-037 reset=0 asserted during LOCK in the same cycle as a granted read -> no rvalid on the next cycle, state=ARB, conflict_cnt=0, and the core wins the first contention after reset releases.
REQ-038 Force 300 contention cycles -> conflict_cnt saturates at 255.
